pc_fetch_unit: RTL and testbench
================================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameters SHALL be:
  - RESET_PC, default 32'h0000_0000, PC value loaded on reset.
  - PC_STEP, default 4, sequential increment in bytes.
REQ-002 Ports SHALL be (name, direction, width, meaning):
  - Clk  in  1  single clock; all state updates on rising edge.
  - Rst  in  1  synchronous, active-high reset.
  - Stall  in  1  hazard hold; blocks PC advance.
  - RedirectEn  in  1  branch/jump taken this cycle.
  - RedirectPC  in  32  branch/jump target.
  - FetchReady  in  1  downstream IF/ID register can accept.
  - FetchValid  out  1  PCOut holds a fetchable address.
  - PCOut  out  32  current fetch address, registered.
  - PCPlus4  out  32  PCOut + PC_STEP, registered, fed to the next-PC select mux.
  - FetchCount  out  32  number of accepted fetches.
  - MisalignErr  out  1  sticky misaligned-redirect flag (see REQ-017).

Function
REQ-003 Accept SHALL be FetchValid & FetchReady & ~Stall, evaluated each cycle.
REQ-004 State machine states SHALL be BOOT, RUN and BUBBLE.
REQ-005 State transitions SHALL be:
  - BOOT -> RUN unconditionally after one cycle.
  - RUN -> BUBBLE on RedirectEn.
  - BUBBLE -> RUN when RedirectEn=0.
  - BUBBLE -> BUBBLE when RedirectEn=1.
REQ-006 FetchValid SHALL be 1 only in RUN.
REQ-007 In RUN with accept and no redirect, PCOut SHALL advance to PCOut+PC_STEP on the next edge, and FetchCount SHALL increment.
REQ-008 In RUN without accept and without redirect, PCOut, PCPlus4 and FetchCount SHALL hold; FetchValid SHALL remain 1 (no valid drop without accept).
REQ-009 RedirectEn SHALL take priority over Stall and over accept in any state except reset: PCOut <= RedirectPC next edge, no FetchCount increment for that cycle, one bubble cycle follows.
REQ-010 RedirectEn asserted during BUBBLE SHALL reload PCOut with the new target (latest target wins) and extend the bubble by one cycle.
REQ-011 RedirectEn during BOOT SHALL load the target and go to BUBBLE.
REQ-012 PCPlus4 SHALL always equal PCOut+PC_STEP modulo 2^32 in the same cycle.
REQ-013 PC arithmetic SHALL be 32-bit unsigned and wrap: 32'hFFFF_FFFC + 4 -> 32'h0000_0000, with no error.
REQ-014 FetchCount SHALL saturate at 32'hFFFF_FFFF.
REQ-015 Latency: every input effect SHALL be visible on outputs exactly one cycle later; there SHALL be no combinational path from inputs to outputs.

Reset
REQ-016 Rst=1 at a rising edge SHALL override all other inputs and set:
  - PCOut=RESET_PC; PCPlus4=RESET_PC+PC_STEP.
  - FetchValid=0; FetchCount=0; MisalignErr=0.
  - state=BOOT.
  Mid-operation reset discards any pending redirect or bubble.

Configuration
REQ-017 With macro PC_ALIGN_CHECK_EN defined:
  - A redirect whose RedirectPC[1:0]!=0 SHALL set MisalignErr (sticky until Rst).
  - That redirect SHALL be ignored: no PC load, no bubble; state continues as if RedirectEn=0.
REQ-018 Without PC_ALIGN_CHECK_EN, RedirectPC SHALL be loaded verbatim and MisalignErr SHALL be tied to 0.

Structure
REQ-019 Shared package pc_fetch_pkg SHALL hold the state enum (BOOT/RUN/BUBBLE), the RESET_PC default and the PC_STEP default.
REQ-020 Next-PC selection (sequential vs redirect, priority per REQ-009) SHALL be one combinational sub-module, pc_next_sel; the state register, PC register and counter stay in pc_fetch_unit.

Verification
REQ-021 Reset then FetchReady=1 -> cycle1 FetchValid=0, PCOut=0; cycle2 FetchValid=1; cycles 3..5 PCOut=4,8,12; FetchCount=3.
REQ-022 Stall=1 for 3 cycles at PCOut=0x10 -> PCOut stays 0x10, FetchValid=1, FetchCount frozen; advances to 0x14 one cycle after Stall drops.
REQ-023 RedirectEn=1, RedirectPC=0x400 with Stall=1 at PCOut=0x20 -> next cycle PCOut=0x400, FetchValid=0; following cycle FetchValid=1. Back-to-back redirects 0x400 then 0x800 -> PCOut=0x800, two bubble cycles.
REQ-024 RESET_PC=32'hFFFF_FFF8, free-run -> PCOut FFFF_FFF8, FFFF_FFFC, 0000_0000 with no error.
REQ-025 With PC_ALIGN_CHECK_EN, redirect to 0x402 -> MisalignErr=1 persisting, PCOut continues sequentially. Without the macro, the same stimulus -> PCOut=0x402.
REQ-026 Rst asserted during BUBBLE -> next cycle PCOut=RESET_PC, state BOOT, FetchCount=0.

Source files
------------

// File: rtl/pc_fetch_pkg.sv
// Shared types and defaults for the PC fetch unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pc_fetch_pkg;

   // Fetch sequencer states: BOOT after reset, RUN while issuing addresses,
   // BUBBLE for the dead cycle that follows a taken redirect.
   typedef enum logic [1:0] {
      BOOT   = 2'd0,
      RUN    = 2'd1,
      BUBBLE = 2'd2
   } fetch_state_e;

   localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] DEF_PC_STEP  = 32'd4;

   // A 32-bit instruction address is fetchable only on a word boundary.
   function automatic logic is_word_aligned(input logic [1:0] pc_lsb);
      return (pc_lsb == 2'b00);
   endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC select: redirect target beats sequential advance beats hold.
// Latency: purely combinational; result is registered by pc_fetch_unit.
// Backpressure: advances only when the current address is accepted (valid & ready & ~stall).
// Optional alignment check enabled by macro PC_ALIGN_CHECK_EN.
module pc_next_sel
   import pc_fetch_pkg::*;
#(
   parameter logic [31:0] PC_STEP = DEF_PC_STEP
) (
   input  logic        fetch_valid_i,
   input  logic        fetch_ready_i,
   input  logic        stall_i,
   input  logic        redirect_en_i,
   input  logic [31:0] redirect_pc_i,
   input  logic [31:0] pc_i,
   input  logic [31:0] pc_plus_i,
   output logic [31:0] next_pc_o,
   output logic [31:0] next_pc_plus_o,
   output logic        redirect_take_o,
   output logic        advance_o,
   output logic        misalign_o
);

   logic accept;

   // Resolve redirect qualification, accept, and the selected next address.
   always_comb begin
      misalign_o      = 1'b0;
      redirect_take_o = 1'b0;
      advance_o       = 1'b0;
      next_pc_o       = pc_i;
      next_pc_plus_o  = pc_plus_i;

`ifdef PC_ALIGN_CHECK_EN
      // A misaligned target is flagged and otherwise behaves as no redirect.
      misalign_o      = redirect_en_i & ~is_word_aligned(redirect_pc_i[1:0]);
      redirect_take_o = redirect_en_i &  is_word_aligned(redirect_pc_i[1:0]);
`else
      redirect_take_o = redirect_en_i;
`endif

      accept    = fetch_valid_i & fetch_ready_i & ~stall_i;
      advance_o = accept & ~redirect_take_o;

      if (redirect_take_o) begin
         next_pc_o = redirect_pc_i;
      end else if (advance_o) begin
         next_pc_o = pc_plus_i;
      end

      // Wraps modulo 2^32 by construction of the 32-bit add.
      next_pc_plus_o = next_pc_o + PC_STEP;
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch PC sequencer with redirect bubbles and an accepted-fetch counter.
// Latency: every input affects outputs on the next rising edge; all outputs are registered.
// Backpressure: PCOut/FetchValid hold while FetchReady=0 or Stall=1; a redirect overrides both.
// Optional misaligned-redirect detection enabled by macro PC_ALIGN_CHECK_EN.
module pc_fetch_unit
   import pc_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEF_RESET_PC,
   parameter logic [31:0] PC_STEP  = DEF_PC_STEP
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        Stall,
   input  logic        RedirectEn,
   input  logic [31:0] RedirectPC,
   input  logic        FetchReady,
   output logic        FetchValid,
   output logic [31:0] PCOut,
   output logic [31:0] PCPlus4,
   output logic [31:0] FetchCount,
   output logic        MisalignErr
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  pc_plus_q, pc_plus_d;
   logic [31:0]  count_q, count_d;
   logic         misalign_q, misalign_d;

   logic         redirect_take;
   logic         advance;
   logic         misalign_hit;

   // Valid is a pure decode of the state register, so no input reaches it combinationally.
   assign FetchValid  = (state_q == RUN);
   assign PCOut       = pc_q;
   assign PCPlus4     = pc_plus_q;
   assign FetchCount  = count_q;
   assign MisalignErr = misalign_q;

   pc_next_sel #(
      .PC_STEP (PC_STEP)
   ) u_next_sel (
      .fetch_valid_i   (FetchValid),
      .fetch_ready_i   (FetchReady),
      .stall_i         (Stall),
      .redirect_en_i   (RedirectEn),
      .redirect_pc_i   (RedirectPC),
      .pc_i            (pc_q),
      .pc_plus_i       (pc_plus_q),
      .next_pc_o       (pc_d),
      .next_pc_plus_o  (pc_plus_d),
      .redirect_take_o (redirect_take),
      .advance_o       (advance),
      .misalign_o      (misalign_hit)
   );

   // Next-state logic: a taken redirect always lands in BUBBLE, otherwise fetch runs.
   always_comb begin
      state_d = state_q;
      case (state_q)
         BOOT:    state_d = redirect_take ? BUBBLE : RUN;
         RUN:     state_d = redirect_take ? BUBBLE : RUN;
         BUBBLE:  state_d = redirect_take ? BUBBLE : RUN;
         default: state_d = BOOT;
      endcase
   end

   // Counter saturates; sticky misalign flag only clears on reset.
   always_comb begin
      count_d    = count_q;
      misalign_d = misalign_q | misalign_hit;
      if (advance && (count_q != 32'hFFFF_FFFF)) begin
         count_d = count_q + 32'd1;
      end
   end

   // State, PC and counter registers with synchronous reset taking priority.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q    <= BOOT;
         pc_q       <= RESET_PC;
         pc_plus_q  <= RESET_PC + PC_STEP;
         count_q    <= 32'd0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         pc_plus_q  <= pc_plus_d;
         count_q    <= count_d;
         misalign_q <= misalign_d;
      end
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios then randomized traffic.
// Latency: checks outputs 1 time unit after each rising edge against a reference model.
// Backpressure: exercised via random FetchReady and Stall.
module tb_pc_fetch_unit;

   logic        Clk = 1'b0;
   logic        Rst, Stall, RedirectEn, FetchReady;
   logic [31:0] RedirectPC;
   logic        FetchValid, MisalignErr;
   logic [31:0] PCOut, PCPlus4, FetchCount;

   logic        wRst;
   logic        w_FetchValid, w_MisalignErr;
   logic [31:0] w_PCOut, w_PCPlus4, w_FetchCount;

   // Reference model: address the DUT should present and whether it is fetchable.
   logic [31:0] m_pc, m_count;
   logic        m_valid, m_err;

   int n_pass   = 0;
   int n_checks = 0;

   always #5 Clk = ~Clk;

   pc_fetch_unit dut (
      .Clk         (Clk),
      .Rst         (Rst),
      .Stall       (Stall),
      .RedirectEn  (RedirectEn),
      .RedirectPC  (RedirectPC),
      .FetchReady  (FetchReady),
      .FetchValid  (FetchValid),
      .PCOut       (PCOut),
      .PCPlus4     (PCPlus4),
      .FetchCount  (FetchCount),
      .MisalignErr (MisalignErr)
   );

   pc_fetch_unit #(
      .RESET_PC (32'hFFFF_FFF8),
      .PC_STEP  (32'd4)
   ) dut_wrap (
      .Clk         (Clk),
      .Rst         (wRst),
      .Stall       (1'b0),
      .RedirectEn  (1'b0),
      .RedirectPC  (32'h0),
      .FetchReady  (1'b1),
      .FetchValid  (w_FetchValid),
      .PCOut       (w_PCOut),
      .PCPlus4     (w_PCPlus4),
      .FetchCount  (w_FetchCount),
      .MisalignErr (w_MisalignErr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Behavioural rules: reset wins; a usable redirect loads the target and makes the
   // next cycle non-fetchable; otherwise an accepted address steps by 4 and is counted.
   task automatic model_step();
      logic aligned, take, accept;
      aligned = (RedirectPC[1:0] == 2'b00);
`ifdef PC_ALIGN_CHECK_EN
      take = RedirectEn && aligned;
`else
      take = RedirectEn;
`endif
      if (Rst) begin
         m_pc    = 32'h0;
         m_valid = 1'b0;
         m_count = 32'h0;
         m_err   = 1'b0;
      end else begin
         accept = m_valid && FetchReady && !Stall;
         if (take) m_pc = RedirectPC;
         else if (accept) m_pc = m_pc + 32'd4;
         if (!take && accept && m_count != 32'hFFFF_FFFF) m_count = m_count + 32'd1;
         m_valid = !take;
`ifdef PC_ALIGN_CHECK_EN
         if (RedirectEn && !aligned) m_err = 1'b1;
`endif
      end
   endtask

   task automatic tick(input string tag);
      model_step();
      @(posedge Clk);
      #1;
      chk({tag, ".pc"},    PCOut,      m_pc);
      chk({tag, ".pc4"},   PCPlus4,    m_pc + 32'd4);
      chk({tag, ".valid"}, {31'd0, FetchValid},  {31'd0, m_valid});
      chk({tag, ".count"}, FetchCount, m_count);
      chk({tag, ".err"},   {31'd0, MisalignErr}, {31'd0, m_err});
   endtask

   initial begin
      Rst = 1'b1; wRst = 1'b1;
      Stall = 1'b0; RedirectEn = 1'b0; RedirectPC = 32'h0; FetchReady = 1'b1;
      m_pc = 32'h0; m_valid = 1'b0; m_count = 32'h0; m_err = 1'b0;

      // Reset state and start-up sequence; wrap instance runs alongside.
      tick("reset");
      chk("c1.valid", {31'd0, FetchValid}, 32'd0);
      chk("c1.pc", PCOut, 32'h0);
      chk("c1.pc4", PCPlus4, 32'h4);
      chk("wrap.c1.pc", w_PCOut, 32'hFFFF_FFF8);
      chk("wrap.c1.valid", {31'd0, w_FetchValid}, 32'd0);
      Rst = 1'b0; wRst = 1'b0;
      tick("boot");
      chk("c2.valid", {31'd0, FetchValid}, 32'd1);
      chk("wrap.c2.pc", w_PCOut, 32'hFFFF_FFF8);
      tick("c3");
      chk("c3.pc", PCOut, 32'h4);
      chk("wrap.c3.pc", w_PCOut, 32'hFFFF_FFFC);
      tick("c4");
      chk("c4.pc", PCOut, 32'h8);
      chk("wrap.c4.pc", w_PCOut, 32'h0000_0000);
      chk("wrap.c4.pc4", w_PCPlus4, 32'h0000_0004);
      chk("wrap.c4.err", {31'd0, w_MisalignErr}, 32'd0);
      tick("c5");
      chk("c5.pc", PCOut, 32'hC);
      chk("c5.count", FetchCount, 32'd3);
      tick("c6");

      // Stall holds at 0x10, then releases.
      Stall = 1'b1;
      repeat (3) tick("stall");
      chk("stall.pc", PCOut, 32'h10);
      chk("stall.valid", {31'd0, FetchValid}, 32'd1);
      chk("stall.count", FetchCount, 32'd4);
      Stall = 1'b0;
      tick("unstall");
      chk("unstall.pc", PCOut, 32'h14);
      repeat (3) tick("run");
      chk("run.pc", PCOut, 32'h20);

      // Redirect beats stall, one bubble.
      Stall = 1'b1; RedirectEn = 1'b1; RedirectPC = 32'h400;
      tick("redir");
      chk("redir.pc", PCOut, 32'h400);
      chk("redir.valid", {31'd0, FetchValid}, 32'd0);
      Stall = 1'b0; RedirectEn = 1'b0;
      tick("redir.after");
      chk("redir.after.valid", {31'd0, FetchValid}, 32'd1);

      // Back-to-back redirects: latest target wins, two bubbles.
      RedirectEn = 1'b1; RedirectPC = 32'h400;
      tick("b2b.1");
      RedirectPC = 32'h800;
      tick("b2b.2");
      chk("b2b.pc", PCOut, 32'h800);
      chk("b2b.valid", {31'd0, FetchValid}, 32'd0);
      RedirectEn = 1'b0;
      tick("b2b.3");
      chk("b2b.3.valid", {31'd0, FetchValid}, 32'd1);
      chk("b2b.count", FetchCount, 32'd8);

      // Misaligned redirect.
      RedirectEn = 1'b1; RedirectPC = 32'h402;
      tick("mis");
`ifdef PC_ALIGN_CHECK_EN
      chk("mis.pc", PCOut, 32'h804);
      chk("mis.err", {31'd0, MisalignErr}, 32'd1);
`else
      chk("mis.pc", PCOut, 32'h402);
      chk("mis.err", {31'd0, MisalignErr}, 32'd0);
`endif
      RedirectEn = 1'b0;
      tick("mis.after");

      // Redirect during BOOT.
      Rst = 1'b1;
      tick("rst2");
      Rst = 1'b0; RedirectEn = 1'b1; RedirectPC = 32'h100;
      tick("bootredir");
      chk("bootredir.pc", PCOut, 32'h100);
      chk("bootredir.valid", {31'd0, FetchValid}, 32'd0);
      RedirectEn = 1'b0;
      tick("bootredir.after");
      repeat (3) tick("run2");

      // Reset in the middle of a bubble discards the pending redirect.
      RedirectEn = 1'b1; RedirectPC = 32'h200;
      tick("bub");
      Rst = 1'b1; RedirectPC = 32'h300;
      tick("bubrst");
      chk("bubrst.pc", PCOut, 32'h0);
      chk("bubrst.count", FetchCount, 32'd0);
      Rst = 1'b0; RedirectEn = 1'b0;
      tick("bubrst.boot");
      chk("bubrst.boot.valid", {31'd0, FetchValid}, 32'd1);

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         Rst        = ($urandom_range(0, 49) == 0);
         Stall      = ($urandom_range(0, 3) == 0);
         FetchReady = ($urandom_range(0, 9) < 7);
         RedirectEn = ($urandom_range(0, 9) == 0);
         RedirectPC = $urandom;
         if ($urandom_range(0, 7) == 0) RedirectPC = 32'hFFFF_FFF4;
         if ($urandom_range(0, 3) != 0) RedirectPC[1:0] = 2'b00;
         tick("rnd");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
